bus_master_arbiter: RTL and testbench

//  Owns the external V33 bus pins and shares them among three masters:
//   - CPU bus control unit (default owner);
//   - internal DMA engine (req/gnt handshake);
//   - external hold requester (hldrq/hldak).

---
 rtl/bus_arb_pkg.sv | 45 ++++
 rtl/bus_master_arbiter_if.sv | 58 +++++
 rtl/arb_burst_limiter.sv | 54 +++++
 rtl/bus_master_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bus_master_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types for the V33 bus master arbiter.
// Pin bundle, owner/state encodings and the idle pin pattern.
package bus_arb_pkg;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] dout;
    logic        n_ube;
    logic        r_w;
    logic        m_io;
    logic        busst0;
    logic        busst1;
    logic        n_bcyst;
    logic        n_dstb;
  } bus_pins_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_EXT  = 2'd3
  } bus_owner_e;

  typedef enum logic [2:0] {
    ST_OWN_CPU = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_OWN_DMA = 3'd2,
    ST_OWN_EXT = 3'd3,
    ST_TURN    = 3'd4
  } arb_state_e;

  // Strobes and byte enable parked inactive, everything else low.
  localparam bus_pins_t BUS_IDLE = '{
    addr:    24'h0,
    dout:    16'h0,
    n_ube:   1'b1,
    r_w:     1'b0,
    m_io:    1'b0,
    busst0:  1'b0,
    busst1:  1'b0,
    n_bcyst: 1'b1,
    n_dstb:  1'b1
  };

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Request/grant handshakes and pin bundles around the arbiter.
// slave: arbiter side; master: requesters and pad ring.
interface bus_master_arbiter_if;
  import bus_arb_pkg::*;

  logic       hldrq;
  logic       hldak;
  logic       cpu_buslock_n;
  logic       cpu_req;
  logic       cpu_bus_idle;
  logic       cpu_hold;
  logic       dma_req;
  logic       dma_gnt;
  logic       dma_cycle_done;
  logic       dma_bus_idle;
  bus_pins_t  cpu_bus;
  bus_pins_t  dma_bus;
  bus_pins_t  pin_bus;
  logic       bus_float;
  bus_owner_e owner;

  modport slave (
    input  hldrq,
    input  cpu_buslock_n,
    input  cpu_req,
    input  cpu_bus_idle,
    input  dma_req,
    input  dma_cycle_done,
    input  dma_bus_idle,
    input  cpu_bus,
    input  dma_bus,
    output hldak,
    output cpu_hold,
    output dma_gnt,
    output pin_bus,
    output bus_float,
    output owner
  );

  modport master (
    output hldrq,
    output cpu_buslock_n,
    output cpu_req,
    output cpu_bus_idle,
    output dma_req,
    output dma_cycle_done,
    output dma_bus_idle,
    output cpu_bus,
    output dma_bus,
    input  hldak,
    input  cpu_hold,
    input  dma_gnt,
    input  pin_bus,
    input  bus_float,
    input  owner
  );

endinterface

// File: rtl/arb_burst_limiter.sv
// DMA burst counter and CPU fairness flag.
// Counter saturates at MAX_BURST; MAX_BURST=0 never limits.
module arb_burst_limiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cnt_clr,
  input  logic cnt_inc,
  input  logic fair_set,
  input  logic fair_clr,
  output logic limit_hit,
  output logic fair
);

  localparam int unsigned CW =
    (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fair_q, fair_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc && cnt_q != MAXC) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    fair_d = fair_q;
    if (fair_set) begin
      fair_d = 1'b1;
    end else if (fair_clr) begin
      fair_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      fair_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fair_q <= fair_d;
    end
  end

  assign limit_hit = (MAX_BURST != 0) && (cnt_q == MAXC);
  assign fair      = fair_q;

endmodule

// File: rtl/bus_master_arbiter.sv
// Shares the external bus among CPU BCU, DMA and hold requester.
// Handover only at cycle boundaries, on ce_2, with a TURN gap.
module bus_master_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter bit          EXT_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  ce_1,
  input logic                  ce_2,
  bus_master_arbiter_if.slave  bus
);

  arb_state_e state_q, state_d;
  logic       idle_seen_q, idle_seen_d;

  logic burst_clr;
  logic burst_inc;
  logic fair_set;
  logic fair_clr;
  logic limit_hit;
  logic fair;

  logic dma_ok;
  logic any_req;
  logic ext_wins;
  logic limit_exit;
  logic dma_exit;

  // ce_1 carries no decision here; all handover happens on ce_2.
  logic unused_ce_1;
  assign unused_ce_1 = ce_1;

  assign dma_ok     = bus.dma_req & ~fair;
  assign any_req    = bus.hldrq | dma_ok;
  assign ext_wins   = bus.hldrq & (EXT_FIRST | ~dma_ok);
  assign limit_exit = limit_hit & bus.cpu_req;
  assign dma_exit   = bus.dma_bus_idle &
                      (~bus.dma_req | bus.hldrq | limit_exit);

  always_comb begin
    state_d     = state_q;
    idle_seen_d = (state_q == ST_DRAIN) ? idle_seen_q : 1'b0;
    burst_clr   = 1'b0;
    fair_set    = 1'b0;
    if (ce_2) begin
      unique case (state_q)
        ST_OWN_CPU: begin
          if (any_req && bus.cpu_buslock_n) begin
            state_d = ST_DRAIN;
          end
        end
        // Two idle samples: the first proves the BCU saw cpu_hold.
        ST_DRAIN: begin
          if (!any_req) begin
            state_d = ST_OWN_CPU;
          end else if (!bus.cpu_bus_idle) begin
            idle_seen_d = 1'b0;
          end else if (!idle_seen_q) begin
            idle_seen_d = 1'b1;
          end else if (ext_wins) begin
            state_d = ST_OWN_EXT;
          end else begin
            state_d   = ST_OWN_DMA;
            burst_clr = 1'b1;
          end
        end
        ST_OWN_DMA: begin
          if (dma_exit) begin
            state_d  = ST_TURN;
            fair_set = limit_exit;
          end
        end
        ST_OWN_EXT: begin
          if (!bus.hldrq) begin
            state_d = ST_TURN;
          end
        end
        ST_TURN: begin
          if (bus.hldrq) begin
            state_d = ST_OWN_EXT;
          end else if (dma_ok) begin
            state_d   = ST_OWN_DMA;
            burst_clr = 1'b1;
          end else begin
            state_d = ST_OWN_CPU;
          end
        end
        default: state_d = ST_OWN_CPU;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OWN_CPU;
      idle_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_seen_q <= idle_seen_d;
    end
  end

  assign burst_inc = ce_2 & bus.dma_cycle_done &
                     (state_q == ST_OWN_DMA);
  assign fair_clr  = ce_2 & (~bus.cpu_req |
                     ((bus.owner == OWN_CPU) &
                      ~bus.cpu_bus.n_bcyst));

  arb_burst_limiter #(
    .MAX_BURST (MAX_BURST)
  ) u_limiter (
    .clk       (clk),
    .reset     (reset),
    .cnt_clr   (burst_clr),
    .cnt_inc   (burst_inc),
    .fair_set  (fair_set),
    .fair_clr  (fair_clr),
    .limit_hit (limit_hit),
    .fair      (fair)
  );

  always_comb begin
    bus.owner     = OWN_CPU;
    bus.cpu_hold  = 1'b1;
    bus.dma_gnt   = 1'b0;
    bus.hldak     = 1'b0;
    bus.bus_float = 1'b0;
    unique case (state_q)
      ST_OWN_CPU: bus.cpu_hold = 1'b0;
      ST_DRAIN:   bus.owner = OWN_CPU;
      ST_OWN_DMA: begin
        bus.owner   = OWN_DMA;
        bus.dma_gnt = 1'b1;
      end
      ST_OWN_EXT: begin
        bus.owner     = OWN_EXT;
        bus.hldak     = 1'b1;
        bus.bus_float = 1'b1;
      end
      ST_TURN:    bus.owner = OWN_NONE;
      default:    bus.cpu_hold = 1'b0;
    endcase
  end

  always_comb begin
    bus.pin_bus = BUS_IDLE;
    unique case (bus.owner)
      OWN_CPU: bus.pin_bus = bus.cpu_bus;
      OWN_DMA: bus.pin_bus = bus.dma_bus;
      default: bus.pin_bus = BUS_IDLE;
    endcase
  end

  a_gnt_excl: assert property (
    @(posedge clk) disable iff (reset)
    !(bus.hldak && bus.dma_gnt));

  a_float_ext: assert property (
    @(posedge clk) disable iff (reset)
    bus.bus_float == (state_q == ST_OWN_EXT));

  a_hold_cpu: assert property (
    @(posedge clk) disable iff (reset)
    !bus.cpu_hold == (state_q == ST_OWN_CPU));

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter (MAX_BURST=4, EXT_FIRST=1).
// Status word: {hldak, dma_gnt, cpu_hold, bus_float, owner}.
module tb_bus_master_arbiter;
  import bus_arb_pkg::*;

  localparam logic [5:0] S_CPU  = 6'b000001;
  localparam logic [5:0] S_DRN  = 6'b001001;
  localparam logic [5:0] S_DMA  = 6'b011010;
  localparam logic [5:0] S_EXT  = 6'b101111;
  localparam logic [5:0] S_TURN = 6'b001000;

  logic clk = 1'b0;
  logic reset;
  logic ce_1;
  logic ce_2;
  int   total = 0;
  int   bad = 0;

  bus_pins_t cpu_pat;
  bus_pins_t dma_pat;
  bus_pins_t idle_pat;
  logic [5:0] st;

  bus_master_arbiter_if bif ();

  bus_master_arbiter #(
    .MAX_BURST (4),
    .EXT_FIRST (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce_1  (ce_1),
    .ce_2  (ce_2),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  assign st = {bif.hldak, bif.dma_gnt, bif.cpu_hold,
               bif.bus_float, bif.owner};

  task automatic cyc();
    ce_1 = 1'b1;
    ce_2 = 1'b0;
    @(posedge clk);
    #1;
    ce_1 = 1'b0;
    ce_2 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bus_pins_t p);
    cpu_pat     = p;
    bif.cpu_bus = p;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", st, S_CPU);
    end
    total++;
    if (bif.pin_bus !== cpu_pat) begin
      bad++;
      $display("FAIL reset_pins got=%h want=%h",
               bif.pin_bus, cpu_pat);
    end
  endtask

  task automatic test_hold();
    bif.hldrq = 1'b1;
    ce_1 = 1'b1;
    ce_2 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL hold_ce1_nochg got=%b want=%b", st, S_CPU);
    end
    cyc();
    total++;
    if (st !== S_DRN) begin
      bad++;
      $display("FAIL hold_drain got=%b want=%b", st, S_DRN);
    end
    cyc();
    total++;
    if (st !== S_DRN) begin
      bad++;
      $display("FAIL hold_idle1 got=%b want=%b", st, S_DRN);
    end
    cyc();
    total++;
    if (st !== S_EXT) begin
      bad++;
      $display("FAIL hold_ext got=%b want=%b", st, S_EXT);
    end
    total++;
    if (bif.pin_bus !== idle_pat) begin
      bad++;
      $display("FAIL hold_pins got=%h want=%h",
               bif.pin_bus, idle_pat);
    end
    bif.hldrq = 1'b0;
    cyc();
    total++;
    if (st !== S_TURN) begin
      bad++;
      $display("FAIL hold_turn got=%b want=%b", st, S_TURN);
    end
    cyc();
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL hold_back got=%b want=%b", st, S_CPU);
    end
  endtask

  task automatic test_buslock();
    bif.cpu_buslock_n = 1'b0;
    bif.hldrq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      total++;
      if (st !== S_CPU) begin
        bad++;
        $display("FAIL lock_hold i=%0d got=%b want=%b",
                 i, st, S_CPU);
      end
    end
    bif.cpu_buslock_n = 1'b1;
    cyc();
    total++;
    if (st !== S_DRN) begin
      bad++;
      $display("FAIL lock_drain got=%b want=%b", st, S_DRN);
    end
    cyc();
    cyc();
    total++;
    if (st !== S_EXT) begin
      bad++;
      $display("FAIL lock_ext got=%b want=%b", st, S_EXT);
    end
    bif.hldrq = 1'b0;
    cyc();
    cyc();
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL lock_back got=%b want=%b", st, S_CPU);
    end
  endtask

  task automatic test_burst();
    bus_pins_t p;
    logic [5:0] exp;
    bif.cpu_req = 1'b1;
    bif.dma_req = 1'b1;
    cyc();
    cyc();
    cyc();
    total++;
    if (st !== S_DMA) begin
      bad++;
      $display("FAIL burst_gnt got=%b want=%b", st, S_DMA);
    end
    total++;
    if (bif.pin_bus !== dma_pat) begin
      bad++;
      $display("FAIL burst_pins got=%h want=%h",
               bif.pin_bus, dma_pat);
    end
    for (int k = 1; k <= 4; k++) begin
      bif.dma_bus_idle = 1'b0;
      bif.dma_cycle_done = 1'b1;
      cyc();
      bif.dma_cycle_done = 1'b0;
      bif.dma_bus_idle = 1'b1;
      cyc();
      exp = (k == 4) ? S_TURN : S_DMA;
      total++;
      if (st !== exp) begin
        bad++;
        $display("FAIL burst_k%0d got=%b want=%b", k, st, exp);
      end
    end
    cyc();
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL burst_cpu got=%b want=%b", st, S_CPU);
    end
    cyc();
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL burst_fair got=%b want=%b", st, S_CPU);
    end
    p = cpu_pat;
    p.n_bcyst = 1'b0;
    set_cpu(p);
    bif.cpu_bus_idle = 1'b0;
    cyc();
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL burst_cpucyc got=%b want=%b", st, S_CPU);
    end
    total++;
    if (bif.pin_bus !== p) begin
      bad++;
      $display("FAIL burst_cpupins got=%h want=%h",
               bif.pin_bus, p);
    end
    p.n_bcyst = 1'b1;
    set_cpu(p);
    cyc();
    total++;
    if (st !== S_DRN) begin
      bad++;
      $display("FAIL burst_redrain got=%b want=%b", st, S_DRN);
    end
    cyc();
    bif.cpu_bus_idle = 1'b1;
    cyc();
    total++;
    if (st !== S_DRN) begin
      bad++;
      $display("FAIL burst_busy got=%b want=%b", st, S_DRN);
    end
    cyc();
    total++;
    if (st !== S_DMA) begin
      bad++;
      $display("FAIL burst_regnt got=%b want=%b", st, S_DMA);
    end
    bif.dma_req = 1'b0;
    cyc();
    cyc();
    bif.cpu_req = 1'b0;
    cyc();
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL burst_end got=%b want=%b", st, S_CPU);
    end
  endtask

  task automatic test_simul();
    bif.hldrq = 1'b1;
    bif.dma_req = 1'b1;
    cyc();
    cyc();
    cyc();
    total++;
    if (st !== S_EXT) begin
      bad++;
      $display("FAIL simul_ext got=%b want=%b", st, S_EXT);
    end
    bif.hldrq = 1'b0;
    cyc();
    total++;
    if (st !== S_TURN) begin
      bad++;
      $display("FAIL simul_turn got=%b want=%b", st, S_TURN);
    end
    cyc();
    total++;
    if (st !== S_DMA) begin
      bad++;
      $display("FAIL simul_dma got=%b want=%b", st, S_DMA);
    end
    bif.dma_req = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_late_ext();
    bif.dma_req = 1'b1;
    cyc();
    cyc();
    bif.hldrq = 1'b1;
    cyc();
    total++;
    if (st !== S_EXT) begin
      bad++;
      $display("FAIL late_ext got=%b want=%b", st, S_EXT);
    end
    bif.hldrq = 1'b0;
    bif.dma_req = 1'b0;
    cyc();
    cyc();
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL late_back got=%b want=%b", st, S_CPU);
    end
  endtask

  task automatic test_reset_dma();
    bif.dma_req = 1'b1;
    cyc();
    cyc();
    cyc();
    total++;
    if (st !== S_DMA) begin
      bad++;
      $display("FAIL rstdma_gnt got=%b want=%b", st, S_DMA);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if (st !== S_CPU) begin
      bad++;
      $display("FAIL rstdma_state got=%b want=%b", st, S_CPU);
    end
    total++;
    if (bif.pin_bus !== cpu_pat) begin
      bad++;
      $display("FAIL rstdma_pins got=%h want=%h",
               bif.pin_bus, cpu_pat);
    end
    bif.dma_req = 1'b0;
    cyc();
  endtask

  task automatic test_withdraw();
    for (int w = 1; w <= 2; w++) begin
      bif.dma_req = 1'b1;
      for (int j = 0; j < w; j++) begin
        cyc();
        total++;
        if (st !== S_DRN) begin
          bad++;
          $display("FAIL wd%0d_drain got=%b want=%b",
                   w, st, S_DRN);
        end
      end
      bif.dma_req = 1'b0;
      cyc();
      total++;
      if (st !== S_CPU) begin
        bad++;
        $display("FAIL wd%0d_back got=%b want=%b", w, st, S_CPU);
      end
    end
  endtask

  initial begin
    cpu_pat = '{addr: 24'hA51234, dout: 16'hBEEF,
                n_ube: 1'b0, r_w: 1'b1, m_io: 1'b1,
                busst0: 1'b1, busst1: 1'b0,
                n_bcyst: 1'b1, n_dstb: 1'b0};
    dma_pat = '{addr: 24'h000F00, dout: 16'h1357,
                n_ube: 1'b1, r_w: 1'b0, m_io: 1'b0,
                busst0: 1'b0, busst1: 1'b1,
                n_bcyst: 1'b0, n_dstb: 1'b1};
    idle_pat = '0;
    idle_pat.n_ube = 1'b1;
    idle_pat.n_bcyst = 1'b1;
    idle_pat.n_dstb = 1'b1;
    reset = 1'b1;
    ce_1 = 1'b0;
    ce_2 = 1'b0;
    bif.hldrq = 1'b0;
    bif.cpu_buslock_n = 1'b1;
    bif.cpu_req = 1'b0;
    bif.cpu_bus_idle = 1'b1;
    bif.dma_req = 1'b0;
    bif.dma_cycle_done = 1'b0;
    bif.dma_bus_idle = 1'b1;
    bif.cpu_bus = cpu_pat;
    bif.dma_bus = dma_pat;
    test_reset();
    test_hold();
    test_buslock();
    test_burst();
    test_simul();
    test_late_ext();
    test_reset_dma();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
